// File: rtl/mole_hit_detector.sv
// Whack detector: synchronises the slide switches, scores hits on lit moles and masks struck moles off LEDR.
// Optional miss penalty (score decrement plus lockout) is enabled by defining MOLE_MISS_PENALTY_EN.
module mole_hit_detector #(
  parameter int unsigned N_LEDS         = 18,
  parameter int unsigned SCORE_MAX      = 9999,
  parameter int unsigned PENALTY_CYCLES = 25_000_000,
  localparam int unsigned SW_W          = $clog2(SCORE_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              game_enable,
  input  logic [N_LEDS-1:0] mole_leds,
  input  logic [N_LEDS-1:0] switches,
  output logic [N_LEDS-1:0] moles_visible,
  output logic [SW_W-1:0]   score,
  output logic              hit_pulse,
  output logic              miss_pulse,
  output logic              locked_out
);

  localparam int unsigned PC_W  = $clog2(N_LEDS + 1);
  localparam int unsigned SUM_W = SW_W + PC_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
`ifdef MOLE_MISS_PENALTY_EN
  localparam logic [1:0] S_LOCK = 2'd2;
  localparam int unsigned LC_W  = (PENALTY_CYCLES > 1) ? $clog2(PENALTY_CYCLES) : 1;
`endif

  function automatic logic [PC_W-1:0] popcount(input logic [N_LEDS-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_LEDS; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [SW_W-1:0] sat_add(input logic [SW_W-1:0] s,
                                              input logic [PC_W-1:0] n);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(s) + SUM_W'(n);
    if (sum > SUM_W'(SCORE_MAX)) return SW_W'(SCORE_MAX);
    return sum[SW_W-1:0];
  endfunction

`ifdef MOLE_MISS_PENALTY_EN
  function automatic logic [SW_W-1:0] floor_sub(input logic [SW_W-1:0] s,
                                                input logic [PC_W-1:0] n);
    if (SUM_W'(n) >= SUM_W'(s)) return '0;
    return s - SW_W'(n);
  endfunction
`endif

  logic [N_LEDS-1:0] s1_q, s2_q, prev_q;
  logic [N_LEDS-1:0] hit_mask_q, hit_mask_d;
  logic [N_LEDS-1:0] mv_q;
  logic [SW_W-1:0]   score_q, score_d;
  logic              hit_q, hit_d, miss_q, miss_d;
  logic [1:0]        state_q, state_d;
  logic [1:0]        warm_q, warm_d;
  logic [N_LEDS-1:0] e, live, hits, misses;
  logic [SW_W-1:0]   score_hit;
`ifdef MOLE_MISS_PENALTY_EN
  logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
`else
  logic              unused_cfg;
  assign unused_cfg = (PENALTY_CYCLES == 0);
`endif

  // Either toggle direction of a synchronised switch is a whack
  assign e      = s2_q ^ prev_q;
  assign live   = mole_leds & ~hit_mask_q;
  assign hits   = e & live;
  assign misses = e & ~live;
  assign score_hit = sat_add(score_q, popcount(hits));

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    hit_mask_d = hit_mask_q & mole_leds;
    warm_d     = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
`ifdef MOLE_MISS_PENALTY_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        hit_mask_d = '0;
        if (game_enable && warm_q == 2'd3) begin
          state_d = S_PLAY;
          score_d = '0;
        end
      end
      S_PLAY: begin
        score_d    = score_hit;
        hit_d      = |hits;
        miss_d     = |misses;
        hit_mask_d = (hit_mask_q | hits) & mole_leds;
`ifdef MOLE_MISS_PENALTY_EN
        // Penalty is taken after the hit add of the same cycle
        if (|misses) begin
          score_d    = floor_sub(score_hit, popcount(misses));
          state_d    = S_LOCK;
          lock_cnt_d = LC_W'(PENALTY_CYCLES - 1);
        end
`endif
        if (!game_enable) state_d = S_IDLE;
      end
`ifdef MOLE_MISS_PENALTY_EN
      S_LOCK: begin
        if (!game_enable)           state_d = S_IDLE;
        else if (lock_cnt_q == '0)  state_d = S_PLAY;
        else                        lock_cnt_d = lock_cnt_q - LC_W'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      hit_mask_q <= '0;
      mv_q       <= '0;
      score_q    <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      state_q    <= S_IDLE;
      warm_q     <= 2'd0;
`ifdef MOLE_MISS_PENALTY_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      s1_q       <= switches;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      hit_mask_q <= hit_mask_d;
      mv_q       <= mole_leds & ~hit_mask_q;
      score_q    <= score_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      state_q    <= state_d;
      warm_q     <= warm_d;
`ifdef MOLE_MISS_PENALTY_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign moles_visible = mv_q;
  assign score         = score_q;
  assign hit_pulse     = hit_q;
  assign miss_pulse    = miss_q;
`ifdef MOLE_MISS_PENALTY_EN
  assign locked_out    = (state_q == S_LOCK);
`else
  assign locked_out    = 1'b0;
`endif

endmodule

// File: tb/tb_mole_hit_detector.sv
// Directed bench for mole_hit_detector with SCORE_MAX=3 and PENALTY_CYCLES=8.
module tb_mole_hit_detector;

  localparam int unsigned N = 18;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          game_enable;
  logic [N-1:0]  mole_leds;
  logic [N-1:0]  switches;
  logic [N-1:0]  moles_visible;
  logic [1:0]    score;
  logic          hit_pulse;
  logic          miss_pulse;
  logic          locked_out;

  int n_checks = 0;
  int n_fail   = 0;

  mole_hit_detector #(
    .N_LEDS(N),
    .SCORE_MAX(3),
    .PENALTY_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .game_enable(game_enable),
    .mole_leds(mole_leds),
    .switches(switches),
    .moles_visible(moles_visible),
    .score(score),
    .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse),
    .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_round(input logic [N-1:0] moles);
    reset_n     = 1'b0;
    game_enable = 1'b0;
    mole_leds   = moles;
    tick(2);
    reset_n     = 1'b1;
    game_enable = 1'b1;
    tick(5);
  endtask

  initial begin
    reset_n     = 1'b0;
    game_enable = 1'b0;
    mole_leds   = 18'h00004;
    switches    = '0;
    tick(3);
    check("rst_score", 32'(score), 0);
    check("rst_mv", 32'(moles_visible), 0);
    check("rst_hit", 32'(hit_pulse), 0);
    check("rst_miss", 32'(miss_pulse), 0);
    check("rst_lock", 32'(locked_out), 0);

    // single hit on SW[2]
    start_round(18'h00004);
    check("idle_mv_follow", 32'(moles_visible), 32'h4);
    switches = switches ^ 18'h00004;
    tick(2);
    check("t1_hit_early", 32'(hit_pulse), 0);
    tick(1);
    check("t1_hit", 32'(hit_pulse), 1);
    check("t1_miss", 32'(miss_pulse), 0);
    check("t1_score", 32'(score), 1);
    check("t1_mv_before", 32'(moles_visible), 32'h4);
    tick(1);
    check("t1_hit_off", 32'(hit_pulse), 0);
    check("t1_mv_masked", 32'(moles_visible), 0);

    // hit then miss on the same mole
    start_round(18'h00004);
    switches = switches ^ 18'h00004;
    tick(3);
    check("t2_hit", 32'(hit_pulse), 1);
    check("t2_score1", 32'(score), 1);
    tick(7);
    switches = switches ^ 18'h00004;
    tick(3);
    check("t2_miss", 32'(miss_pulse), 1);
    check("t2_nohit", 32'(hit_pulse), 0);
`ifdef MOLE_MISS_PENALTY_EN
    check("t2_score_pen", 32'(score), 0);
    check("t2_lock_start", 32'(locked_out), 1);
    tick(7);
    check("t2_lock_last", 32'(locked_out), 1);
    tick(1);
    check("t2_lock_end", 32'(locked_out), 0);
`else
    check("t2_score", 32'(score), 1);
    check("t2_lock", 32'(locked_out), 0);
`endif

    // simultaneous hits and miss
    start_round(18'h00021);
    switches = switches ^ 18'h00221;
    tick(3);
    check("t3_hit", 32'(hit_pulse), 1);
    check("t3_miss", 32'(miss_pulse), 1);
`ifdef MOLE_MISS_PENALTY_EN
    check("t3_score", 32'(score), 1);
`else
    check("t3_score", 32'(score), 2);
`endif
    check("t3_mv_before", 32'(moles_visible), 32'h21);

    // despawn and respawn of mole 3
    start_round(18'h00008);
    switches = switches ^ 18'h00008;
    tick(3);
    check("t4_hit1", 32'(hit_pulse), 1);
    tick(1);
    check("t4_mv_gone", 32'(moles_visible), 0);
    mole_leds = '0;
    tick(1);
    mole_leds = 18'h00008;
    tick(1);
    check("t4_mv_back", 32'(moles_visible), 32'h8);
    switches = switches ^ 18'h00008;
    tick(3);
    check("t4_hit2", 32'(hit_pulse), 1);
    check("t4_miss2", 32'(miss_pulse), 0);
    check("t4_score", 32'(score), 2);

    // saturation at SCORE_MAX=3
    start_round(18'h0001F);
    for (int i = 0; i < 5; i++) begin
      switches = switches ^ (18'h1 << i);
      tick(3);
      check("t5_hit", 32'(hit_pulse), 1);
      check("t5_score", 32'(score), (i < 3) ? i + 1 : 3);
      tick(1);
    end
    game_enable = 1'b0;
    tick(1);
    check("t5_held", 32'(score), 3);
    game_enable = 1'b1;
    tick(1);
    check("t5_cleared", 32'(score), 0);

    // switches high through reset, enable from cycle 0
    switches    = '1;
    mole_leds   = 18'h3FFFF;
    game_enable = 1'b1;
    reset_n     = 1'b0;
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t6_nohit", 32'(hit_pulse), 0);
      check("t6_nomiss", 32'(miss_pulse), 0);
    end
    check("t6_score", 32'(score), 0);
    check("t6_mv", 32'(moles_visible), 32'h3FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
